mul_seq32: RTL and testbench



---
 rtl/mul_pkg.sv | 7 +
 rtl/fulladder32.sv | 10 +
 rtl/mul_seq32.sv | 89 ++++++++
 tb/tb_mul_seq32.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and sizing for the sequential multiplier.
package mul_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
    localparam int MUL_ITER = 32;
    localparam int CNT_W = 5;
    localparam int PROD_W = 64;
endpackage

// File: rtl/fulladder32.sv
// fulladder32: 32-bit adder with carry in/out, the multiplier's only datapath adder.
module fulladder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        carry_i,
    output logic [31:0] sum_o,
    output logic        carry_o
);
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'b0, carry_i};
endmodule

// File: rtl/mul_seq32.sv
// mul_seq32: iterative 32x32->64 shift-add multiplier, one multiplier bit per cycle.
// MUL_SIGNED_EN adds signed_i: magnitudes are multiplied and the result negated in one extra cycle.
module mul_seq32
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
`ifdef MUL_SIGNED_EN
    input  logic              signed_i,
`endif
    output logic              valid_o,
    input  logic              ready_i,
    output logic [PROD_W-1:0] prod_o,
    output logic              busy_o
);
    if (WIDTH != 32) begin : g_bad_width
        $error("mul_seq32 supports WIDTH=32 only");
    end
    mul_state_t        r_state, w_next;
    logic [WIDTH-1:0]  r_a;
    logic [PROD_W-1:0] r_p;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sign, r_neg;
    logic [WIDTH-1:0]  w_sum, w_a_in, w_b_in;
    logic              w_carry, w_sign_in, w_accept, w_shift, w_last, w_fin;
`ifdef MUL_SIGNED_EN
    assign w_a_in    = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign w_b_in    = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    assign w_sign_in = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`else
    assign w_a_in    = a_i;
    assign w_b_in    = b_i;
    assign w_sign_in = 1'b0;
`endif
    fulladder32 u_add (
        .a_i    (r_p[PROD_W-1:WIDTH]),
        .b_i    (r_p[0] ? r_a : '0),
        .carry_i(1'b0),
        .sum_o  (w_sum),
        .carry_o(w_carry)
    );
    assign w_accept = valid_i && ready_o;
    assign w_shift  = (r_state == BUSY) && !r_neg;
    assign w_last   = r_cnt == CNT_W'(MUL_ITER - 1);
    // a pending negate takes one more BUSY edge before DONE
    assign w_fin    = r_neg || (w_last && !r_sign);
    assign ready_o  = r_state == IDLE;
    assign valid_o  = r_state == DONE;
    assign busy_o   = r_state != IDLE;
    assign prod_o   = r_p;
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (valid_i ? BUSY : IDLE) :
                 (r_state == BUSY) ? (w_fin ? DONE : BUSY) :
                 (ready_i ? IDLE : DONE);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a    <= '0;
            r_p    <= '0;
            r_cnt  <= '0;
            r_sign <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_accept) begin
            r_a    <= w_a_in;
            r_p    <= {{WIDTH{1'b0}}, w_b_in};
            r_cnt  <= '0;
            r_sign <= w_sign_in;
            r_neg  <= 1'b0;
        end else if (w_shift) begin
            r_p    <= {w_carry, w_sum, r_p[WIDTH-1:1]};
            r_cnt  <= r_cnt + CNT_W'(1);
            r_neg  <= w_last && r_sign;
        end else if (r_state == BUSY) begin
            r_p    <= -r_p;
            r_sign <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mul_seq32.sv
// tb_mul_seq32: directed and random checks of mul_seq32 against an arithmetic product model.
module tb_mul_seq32;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
`ifdef MUL_SIGNED_EN
    logic        signed_i = 1'b0;
`endif
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [63:0] prod_o;
    logic        busy_o;
    int          checks = 0;
    int          errors = 0;

    mul_seq32 dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .a_i    (a_i),
        .b_i    (b_i),
`ifdef MUL_SIGNED_EN
        .signed_i(signed_i),
`endif
        .valid_o(valid_o),
        .ready_i(ready_i),
        .prod_o (prod_o),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic rdy_early, input int rdy_wait);
        logic [63:0] exp;
        int n, lat;
        exp = sgn ? 64'(longint'($signed(a)) * longint'($signed(b))) : 64'(a) * 64'(b);
        lat = (sgn && (a[31] ^ b[31])) ? 33 : 32;
        a_i = a;
        b_i = b;
`ifdef MUL_SIGNED_EN
        signed_i = sgn;
`endif
        ready_i = rdy_early;
        valid_i = 1'b1;
        chk("ready_before_accept", 64'(ready_o), 64'd1);
        tick();
        valid_i = 1'b0;
        a_i = $urandom;
        b_i = $urandom;
        chk("busy_after_accept", 64'({busy_o, ready_o}), 64'b10);
        n = 0;
        while (!valid_o && n < 200) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("product", prod_o, exp);
        if (!rdy_early) begin
            repeat (rdy_wait) tick();
            chk("held_product", {prod_o[62:0], valid_o}, {exp[62:0], 1'b1});
            ready_i = 1'b1;
        end
        tick();
        ready_i = 1'b0;
        chk("released", 64'({valid_o, ready_o, busy_o}), 64'b010);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int n;
        repeat (2) tick();
        rst_i = 1'b0;
        chk("reset_state", {prod_o[60:0], ready_o, valid_o, busy_o}, {61'd0, 3'b100});

        a_i = 32'd5;
        b_i = 32'd7;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (5) tick();
        chk("mid_busy", 64'({busy_o, ready_o}), 64'b10);
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        chk("abort_outputs", {prod_o[60:0], ready_o, valid_o, busy_o}, {61'd0, 3'b100});
        run_op(32'd3, 32'd4, 1'b0, 1'b0, 0);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
        chk("max_square", prod_o, 64'hFFFF_FFFE_0000_0001);
        run_op(32'h1234_5678, 32'd0, 1'b0, 1'b0, 1);
        run_op(32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2);

        a_i = 32'd6;
        b_i = 32'd7;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 200) begin
            tick();
            n++;
        end
        chk("bp_latency", 64'(n), 64'd32);
        for (int i = 0; i < 10; i++) begin
            valid_i = i[0];
            a_i = $urandom;
            b_i = $urandom;
            tick();
            chk("bp_hold", {prod_o[61:0], valid_o, ready_o}, {62'd42, 2'b10});
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("bp_release", 64'({valid_o, ready_o}), 64'b01);

        ready_i = 1'b1;
        valid_i = 1'b1;
        a_i = 32'd2;
        b_i = 32'd3;
        tick();
        a_i = 32'd10;
        b_i = 32'd10;
        n = 0;
        while (!valid_o && n < 200) begin
            tick();
            n++;
        end
        chk("b2b_first_latency", 64'(n), 64'd32);
        chk("b2b_first", prod_o, 64'd6);
        tick();
        chk("b2b_idle_edge33", 64'({ready_o, busy_o}), 64'b10);
        tick();
        chk("b2b_accept_edge34", 64'({ready_o, busy_o}), 64'b01);
        valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 200) begin
            tick();
            n++;
        end
        chk("b2b_second_latency", 64'(n), 64'd32);
        chk("b2b_second", prod_o, 64'd100);
        tick();
        ready_i = 1'b0;

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'h8000_0000;
            if (i == 1) rb = 32'd1;
            run_op(ra, rb, 1'b0, i[0], int'($urandom_range(0, 3)));
        end

`ifdef MUL_SIGNED_EN
        run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 1);
        chk("signed_neg3x7", prod_o, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 1);
        chk("unsigned_neg3x7", prod_o, 64'h0000_0006_FFFF_FFEB);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 0);
        run_op(32'h8000_0000, 32'd3, 1'b1, 1'b1, 0);
        for (int i = 0; i < 12; i++) begin
            run_op($urandom, $urandom, 1'b1, i[0], int'($urandom_range(0, 2)));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
